// File: rtl/touch_gesture_pkg.sv
// Shared definitions for the touch gesture engine: event codes and FSM states.
package touch_gesture_pkg;

    localparam logic [2:0] GEST_NONE  = 3'd0;
    localparam logic [2:0] GEST_TAP   = 3'd1;
    localparam logic [2:0] GEST_DTAP  = 3'd2;
    localparam logic [2:0] GEST_LONG  = 3'd3;
    localparam logic [2:0] GEST_RIGHT = 3'd4;
    localparam logic [2:0] GEST_LEFT  = 3'd5;
    localparam logic [2:0] GEST_DOWN  = 3'd6;
    localparam logic [2:0] GEST_UP    = 3'd7;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRESS     = 3'd1,
        HOLD      = 3'd2,
        MOVE      = 3'd3,
        WAIT_DTAP = 3'd4,
        PRESS2    = 3'd5
    } gest_state_t;

endpackage

// File: rtl/touch_delta_classifier.sv
// Combinational displacement classifier: signed deltas, swipe threshold flag
// and 4-way direction (ties go to the horizontal axis).
module touch_delta_classifier
    import touch_gesture_pkg::*;
#(
    parameter int COORD_W    = 10,
    parameter int SWIPE_DIST = 32
) (
    input  logic [COORD_W-1:0]        start_x,
    input  logic [COORD_W-1:0]        start_y,
    input  logic [COORD_W-1:0]        cur_x,
    input  logic [COORD_W-1:0]        cur_y,
    output logic signed [COORD_W:0]   dx,
    output logic signed [COORD_W:0]   dy,
    output logic                      exceed,
    output logic [2:0]                dir
);

    localparam logic [COORD_W:0] SWIPE_T = (COORD_W+1)'(SWIPE_DIST);

    logic [COORD_W:0] adx;
    logic [COORD_W:0] ady;

    // Deltas at one extra bit so the full coordinate range cannot overflow
    always_comb begin
        dx  = $signed({1'b0, cur_x}) - $signed({1'b0, start_x});
        dy  = $signed({1'b0, cur_y}) - $signed({1'b0, start_y});
        adx = dx[COORD_W] ? $unsigned(-dx) : $unsigned(dx);
        ady = dy[COORD_W] ? $unsigned(-dy) : $unsigned(dy);
        exceed = (adx > SWIPE_T) || (ady > SWIPE_T);
        if (adx >= ady)
            dir = dx[COORD_W] ? GEST_LEFT : GEST_RIGHT;
        else
            dir = (!dy[COORD_W] && (dy != '0)) ? GEST_DOWN : GEST_UP;
    end

endmodule

// File: rtl/touch_gesture_engine.sv
// Gesture recogniser: tap, double-tap, long-press and 4-way swipe from the
// mapped touch stream. One registered event pulse per gesture.
module touch_gesture_engine
    import touch_gesture_pkg::*;
#(
    parameter int COORD_W        = 10,
    parameter int TIMER_W        = 16,
    parameter int LONG_PRESS_CYC = 1000,
    parameter int DTAP_GAP_CYC   = 300,
    parameter int SWIPE_DIST     = 32,
    parameter int DTAP_EN        = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     touch_down,
    input  logic [COORD_W-1:0]       touch_x,
    input  logic [COORD_W-1:0]       touch_y,
    output logic                     gest_valid,
    output logic [2:0]               gest_code,
    output logic signed [COORD_W:0]  gest_dx,
    output logic signed [COORD_W:0]  gest_dy,
    output logic                     busy
);

    localparam logic [TIMER_W-1:0] LONG_LAST = TIMER_W'(LONG_PRESS_CYC - 1);
    localparam logic [TIMER_W-1:0] GAP_LAST  = TIMER_W'(DTAP_GAP_CYC - 1);

    gest_state_t          state;
    logic [TIMER_W-1:0]   timer;
    logic [TIMER_W-1:0]   timer_inc;
    logic [COORD_W-1:0]   start_x, start_y;
    logic [COORD_W-1:0]   cur_x, cur_y;
    logic [COORD_W-1:0]   cls_x, cls_y;
    logic signed [COORD_W:0] cls_dx, cls_dy;
    logic                 cls_exceed;
    logic [2:0]           cls_dir;

    // MOVE classifies from the last latched point; elsewhere use live input
    always_comb begin
        cls_x     = (state == MOVE) ? cur_x : touch_x;
        cls_y     = (state == MOVE) ? cur_y : touch_y;
        timer_inc = (timer == '1) ? timer : timer + 1'b1;
    end

    touch_delta_classifier #(
        .COORD_W    (COORD_W),
        .SWIPE_DIST (SWIPE_DIST)
    ) u_cls (
        .start_x (start_x),
        .start_y (start_y),
        .cur_x   (cls_x),
        .cur_y   (cls_y),
        .dx      (cls_dx),
        .dy      (cls_dy),
        .exceed  (cls_exceed),
        .dir     (cls_dir)
    );

    assign busy = (state != IDLE);

    // Gesture FSM, timer and registered event outputs. Timeouts use >= so a
    // PRESS2->PRESS demotion (timer kept, still counting) still fires LONG.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            timer      <= '0;
            start_x    <= '0;
            start_y    <= '0;
            cur_x      <= '0;
            cur_y      <= '0;
            gest_valid <= 1'b0;
            gest_code  <= GEST_NONE;
            gest_dx    <= '0;
            gest_dy    <= '0;
        end else begin
            gest_valid <= 1'b0;
            case (state)
                IDLE: begin
                    timer <= '0;
                    if (touch_down) begin
                        start_x <= touch_x;
                        start_y <= touch_y;
                        cur_x   <= touch_x;
                        cur_y   <= touch_y;
                        state   <= PRESS;
                    end
                end
                PRESS: begin
                    timer <= timer_inc;
                    if (!touch_down) begin
                        timer <= '0;
                        if (DTAP_EN != 0) begin
                            state <= WAIT_DTAP;
                        end else begin
                            gest_valid <= 1'b1;
                            gest_code  <= GEST_TAP;
                            gest_dx    <= '0;
                            gest_dy    <= '0;
                            state      <= IDLE;
                        end
                    end else if (cls_exceed) begin
                        cur_x <= touch_x;
                        cur_y <= touch_y;
                        timer <= '0;
                        state <= MOVE;
                    end else if (timer >= LONG_LAST) begin
                        gest_valid <= 1'b1;
                        gest_code  <= GEST_LONG;
                        gest_dx    <= '0;
                        gest_dy    <= '0;
                        timer      <= '0;
                        state      <= HOLD;
                    end
                end
                HOLD: begin
                    if (!touch_down) begin
                        timer <= '0;
                        state <= IDLE;
                    end
                end
                MOVE: begin
                    if (touch_down) begin
                        cur_x <= touch_x;
                        cur_y <= touch_y;
                    end else begin
                        gest_valid <= 1'b1;
                        gest_code  <= cls_dir;
                        gest_dx    <= cls_dx;
                        gest_dy    <= cls_dy;
                        timer      <= '0;
                        state      <= IDLE;
                    end
                end
                WAIT_DTAP: begin
                    timer <= timer_inc;
                    if (touch_down) begin
                        start_x <= touch_x;
                        start_y <= touch_y;
                        cur_x   <= touch_x;
                        cur_y   <= touch_y;
                        timer   <= '0;
                        state   <= PRESS2;
                    end else if (timer >= GAP_LAST) begin
                        gest_valid <= 1'b1;
                        gest_code  <= GEST_TAP;
                        gest_dx    <= '0;
                        gest_dy    <= '0;
                        timer      <= '0;
                        state      <= IDLE;
                    end
                end
                PRESS2: begin
                    timer <= timer_inc;
                    if (!touch_down) begin
                        gest_valid <= 1'b1;
                        gest_code  <= GEST_DTAP;
                        gest_dx    <= '0;
                        gest_dy    <= '0;
                        timer      <= '0;
                        state      <= IDLE;
                    end else if (cls_exceed || (timer >= LONG_LAST)) begin
                        // First tap is reported; second press carries on as a
                        // normal PRESS with start and timer preserved.
                        gest_valid <= 1'b1;
                        gest_code  <= GEST_TAP;
                        gest_dx    <= '0;
                        gest_dy    <= '0;
                        state      <= PRESS;
                    end
                end
                default: begin
                    timer <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_touch_gesture_engine.sv
// Directed bench for touch_gesture_engine (LONG=20, GAP=10, SWIPE=8).
// Inputs change on the falling edge; outputs are observed on the falling
// edge right after the rising edge that sampled them.
module tb_touch_gesture_engine;

    logic              clk;
    logic              reset;
    logic              touch_down;
    logic [9:0]        touch_x, touch_y;
    logic              gest_valid, gv0;
    logic [2:0]        gest_code, gc0;
    logic signed [10:0] gest_dx, gest_dy, gdx0, gdy0;
    logic              busy, busy0;

    int checks = 0;
    int errs   = 0;
    int cyc, ev_n, ev_code, ev_dx, ev_dy, ev_at, first_code, first_at;
    int ev0_n, ev0_code, ev0_at;

    touch_gesture_engine #(
        .COORD_W(10), .TIMER_W(16), .LONG_PRESS_CYC(20),
        .DTAP_GAP_CYC(10), .SWIPE_DIST(8), .DTAP_EN(1)
    ) dut (
        .clk(clk), .reset(reset), .touch_down(touch_down),
        .touch_x(touch_x), .touch_y(touch_y),
        .gest_valid(gest_valid), .gest_code(gest_code),
        .gest_dx(gest_dx), .gest_dy(gest_dy), .busy(busy)
    );

    touch_gesture_engine #(
        .COORD_W(10), .TIMER_W(16), .LONG_PRESS_CYC(20),
        .DTAP_GAP_CYC(10), .SWIPE_DIST(8), .DTAP_EN(0)
    ) dut0 (
        .clk(clk), .reset(reset), .touch_down(touch_down),
        .touch_x(touch_x), .touch_y(touch_y),
        .gest_valid(gv0), .gest_code(gc0),
        .gest_dx(gdx0), .gest_dy(gdy0), .busy(busy0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock of stimulus; records any event pulses seen after the edge
    task automatic cycle(input logic d, input int x, input int y);
        touch_down = d;
        touch_x    = 10'(x);
        touch_y    = 10'(y);
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (gest_valid) begin
            if (ev_n == 0) begin
                first_code = int'(gest_code);
                first_at   = cyc;
            end
            ev_n++;
            ev_code = int'(gest_code);
            ev_dx   = int'(gest_dx);
            ev_dy   = int'(gest_dy);
            ev_at   = cyc;
        end
        if (gv0) begin
            ev0_n++;
            ev0_code = int'(gc0);
            ev0_at   = cyc;
        end
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        touch_down = 1'b0;
        touch_x    = '0;
        touch_y    = '0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        cyc = 0; ev_n = 0; ev_code = 0; ev_dx = 0; ev_dy = 0; ev_at = 0;
        first_code = 0; first_at = 0;
        ev0_n = 0; ev0_code = 0; ev0_at = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (gest_valid !== 1'b0) begin errs++; $display("FAIL reset_valid got %b want 0", gest_valid); end
        checks++; if (gest_code !== 3'd0) begin errs++; $display("FAIL reset_code got %0d want 0", gest_code); end
        checks++; if (gest_dx !== 11'sd0 || gest_dy !== 11'sd0) begin errs++; $display("FAIL reset_dxdy got %0d/%0d want 0/0", gest_dx, gest_dy); end
        checks++; if (busy !== 1'b0 || busy0 !== 1'b0) begin errs++; $display("FAIL reset_busy got %b/%b want 0/0", busy, busy0); end
    endtask

    // Tap: 5 down, 12 up -> TAP on the 11th up cycle (10 cycles after release)
    task automatic test_tap();
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1'b1, 100, 100);
        for (int i = 1; i <= 12; i++) begin
            cycle(1'b0, 0, 0);
            if (i == 10) begin
                checks++; if (busy !== 1'b1) begin errs++; $display("FAIL tap_busy_before got %b want 1", busy); end
            end
            if (i == 11) begin
                checks++; if (busy !== 1'b0) begin errs++; $display("FAIL tap_busy_drop got %b want 0", busy); end
            end
        end
        checks++; if (ev_n !== 1) begin errs++; $display("FAIL tap_count got %0d want 1", ev_n); end
        checks++; if (ev_code !== 1) begin errs++; $display("FAIL tap_code got %0d want 1", ev_code); end
        checks++; if (ev_dx !== 0 || ev_dy !== 0) begin errs++; $display("FAIL tap_dxdy got %0d/%0d want 0/0", ev_dx, ev_dy); end
        checks++; if (ev_at !== 16) begin errs++; $display("FAIL tap_time got %0d want 16", ev_at); end
    endtask

    task automatic test_double_tap();
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1'b1, 100, 100);
        for (int i = 0; i < 4; i++) cycle(1'b0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(1'b1, 102, 101);
        for (int i = 0; i < 12; i++) cycle(1'b0, 0, 0);
        checks++; if (ev_n !== 1) begin errs++; $display("FAIL dtap_count got %0d want 1", ev_n); end
        checks++; if (ev_code !== 2) begin errs++; $display("FAIL dtap_code got %0d want 2", ev_code); end
        checks++; if (ev_at !== 15) begin errs++; $display("FAIL dtap_time got %0d want 15", ev_at); end
    endtask

    // First down cycle is sampled in IDLE, then 20 PRESS cycles -> pulse at 21
    task automatic test_long_press();
        do_reset();
        for (int i = 0; i < 30; i++) cycle(1'b1, 50, 50);
        for (int i = 0; i < 4; i++) cycle(1'b0, 0, 0);
        checks++; if (ev_n !== 1) begin errs++; $display("FAIL long_count got %0d want 1", ev_n); end
        checks++; if (ev_code !== 3) begin errs++; $display("FAIL long_code got %0d want 3", ev_code); end
        checks++; if (ev_at !== 21) begin errs++; $display("FAIL long_time got %0d want 21", ev_at); end
        checks++; if (ev_dx !== 0 || ev_dy !== 0) begin errs++; $display("FAIL long_dxdy got %0d/%0d want 0/0", ev_dx, ev_dy); end
        checks++; if (busy !== 1'b0) begin errs++; $display("FAIL long_busy got %b want 0", busy); end
    endtask

    // 2 cycles at start, 3 at end, release with junk coords -> event at cycle 6
    task automatic test_swipe(input string nm, input int sx, input int sy,
                              input int ex, input int ey, input int code,
                              input int edx, input int edy);
        do_reset();
        for (int i = 0; i < 2; i++) cycle(1'b1, sx, sy);
        for (int i = 0; i < 3; i++) cycle(1'b1, ex, ey);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1023, 0);
        checks++; if (ev_n !== 1) begin errs++; $display("FAIL %s_count got %0d want 1", nm, ev_n); end
        checks++; if (ev_code !== code) begin errs++; $display("FAIL %s_code got %0d want %0d", nm, ev_code, code); end
        checks++; if (ev_dx !== edx || ev_dy !== edy) begin errs++; $display("FAIL %s_dxdy got %0d/%0d want %0d/%0d", nm, ev_dx, ev_dy, edx, edy); end
        checks++; if (ev_at !== 6) begin errs++; $display("FAIL %s_time got %0d want 6", nm, ev_at); end
    endtask

    task automatic test_threshold();
        do_reset();
        for (int i = 0; i < 2; i++) cycle(1'b1, 100, 100);
        for (int i = 0; i < 3; i++) cycle(1'b1, 108, 100);
        for (int i = 0; i < 12; i++) cycle(1'b0, 0, 0);
        checks++; if (ev_n !== 1 || ev_code !== 1) begin errs++; $display("FAIL thr8_event got n=%0d code=%0d want n=1 code=1", ev_n, ev_code); end
        checks++; if (ev_at !== 16) begin errs++; $display("FAIL thr8_time got %0d want 16", ev_at); end
        test_swipe("thr9", 100, 100, 109, 100, 4, 9, 0);
    endtask

    // Second press turns into a swipe: TAP for the first tap, then RIGHT
    task automatic test_demote();
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, 100, 100);
        for (int i = 0; i < 2; i++) cycle(1'b0, 0, 0);
        cycle(1'b1, 100, 100);
        cycle(1'b1, 120, 100);
        cycle(1'b1, 120, 100);
        for (int i = 0; i < 3; i++) cycle(1'b0, 0, 0);
        checks++; if (ev_n !== 2) begin errs++; $display("FAIL demote_count got %0d want 2", ev_n); end
        checks++; if (first_code !== 1 || first_at !== 7) begin errs++; $display("FAIL demote_tap got code=%0d at=%0d want code=1 at=7", first_code, first_at); end
        checks++; if (ev_code !== 4 || ev_dx !== 20 || ev_dy !== 0 || ev_at !== 9) begin errs++; $display("FAIL demote_swipe got code=%0d dx=%0d dy=%0d at=%0d want 4/20/0/9", ev_code, ev_dx, ev_dy, ev_at); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        cycle(1'b1, 100, 100);
        cycle(1'b1, 100, 100);
        checks++; if (busy !== 1'b1) begin errs++; $display("FAIL midrst_busy_pre got %b want 1", busy); end
        reset = 1'b1;
        cycle(1'b1, 100, 100);
        reset = 1'b0;
        checks++; if (busy !== 1'b0 || busy0 !== 1'b0) begin errs++; $display("FAIL midrst_busy got %b/%b want 0/0", busy, busy0); end
        for (int i = 0; i < 14; i++) cycle(1'b0, 0, 0);
        checks++; if (ev_n !== 0 || ev0_n !== 0) begin errs++; $display("FAIL midrst_events got %0d/%0d want 0/0", ev_n, ev0_n); end
    endtask

    task automatic test_dtap_off();
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1'b1, 100, 100);
        for (int i = 0; i < 3; i++) cycle(1'b0, 0, 0);
        checks++; if (ev0_n !== 1 || ev0_code !== 1) begin errs++; $display("FAIL nodtap_event got n=%0d code=%0d want n=1 code=1", ev0_n, ev0_code); end
        checks++; if (ev0_at !== 6) begin errs++; $display("FAIL nodtap_time got %0d want 6", ev0_at); end
        checks++; if (busy0 !== 1'b0) begin errs++; $display("FAIL nodtap_busy got %b want 0", busy0); end
    endtask

    initial begin
        reset = 1'b1;
        touch_down = 1'b0;
        touch_x = '0;
        touch_y = '0;
        test_reset();
        test_tap();
        test_double_tap();
        test_long_press();
        test_swipe("right", 100, 100, 140, 110, 4, 40, 10);
        test_swipe("up", 200, 200, 195, 150, 7, -5, -50);
        test_swipe("tie", 300, 300, 280, 320, 5, -20, 20);
        test_threshold();
        test_demote();
        test_mid_reset();
        test_dtap_off();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
        $finish;
    end

endmodule

// File: doc/touch_gesture_engine.md
Name: touch_gesture_engine

Overview:
- Parametrised gesture recogniser that consumes the registered touch stream after coordinate mapping.
- Classifies tap, double-tap, long-press and 4-direction swipe using cycle timers and displacement thresholds.
- Emits one registered event pulse per gesture with a code and a signed displacement.
- Sits between the coordinate mapper and the application and display logic, replacing the fixed-width tap/swipe FSM.

Parameters:
- COORD_W, 10, coordinate width in bits.
- TIMER_W, 16, gesture timer width. The timer saturates at 2^TIMER_W-1.
- LONG_PRESS_CYC, 1000, number of stationary down cycles before a long-press fires. Must be less than 2^TIMER_W.
- DTAP_GAP_CYC, 300, maximum number of up cycles between two taps for them to count as a double-tap. Must be less than 2^TIMER_W.
- SWIPE_DIST, 32, displacement threshold. A press becomes a swipe when |dx| > SWIPE_DIST or |dy| > SWIPE_DIST (strictly greater).
- DTAP_EN, 1, double-tap mode. 1 enables double-tap detection. 0 reports every tap immediately at release.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- touch_down  in  1  level signal: finger in contact this cycle
- touch_x  in  COORD_W  unsigned X coordinate; meaningful only while touch_down=1
- touch_y  in  COORD_W  unsigned Y coordinate; meaningful only while touch_down=1
- gest_valid  out  1  one-cycle event pulse
- gest_code  out  3  event code: 0 none, 1 TAP, 2 DTAP, 3 LONG, 4 RIGHT, 5 LEFT, 6 DOWN, 7 UP
- gest_dx  out  COORD_W+1  signed end-minus-start X; zero for non-swipe events
- gest_dy  out  COORD_W+1  signed end-minus-start Y; zero for non-swipe events
- busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- One clock, clk. Reset is synchronous and active-high, sampled at the posedge.
- Reset values: state IDLE, timer 0, all registers 0, gest_valid=0, gest_code=0, gest_dx=0, gest_dy=0, busy=0.
- Reset mid-gesture aborts the gesture with no event.
- Latency: event outputs are registered. gest_valid is asserted on the edge after the cycle in which the trigger condition is sampled.
- gest_code, gest_dx and gest_dy hold their values until the next event.
- At most one event is emitted per cycle.
- The timer increments by 1 each cycle in PRESS, PRESS2 and WAIT_DTAP, saturating at its maximum. It clears on every state entry except PRESS2->PRESS.
- Displacement: dx = cur_x - start_x and dy = cur_y - start_y, computed at COORD_W+1 signed width. abs() is taken at the same width.
- Within a state, conditions are evaluated in priority order: release first, then displacement, then timeout.
- IDLE: on touch_down=1, latch start=cur=(touch_x, touch_y) and go to PRESS.
- PRESS, on release:
  - DTAP_EN=1: go to WAIT_DTAP.
  - DTAP_EN=0: emit TAP and go to IDLE.
- PRESS, displacement exceeds SWIPE_DIST: go to MOVE and latch cur.
- PRESS, timeout: when the timer reaches LONG_PRESS_CYC-1, emit LONG and go to HOLD.
- HOLD: ignores all motion. On release, go to IDLE with no event.
- MOVE: latch cur each down cycle. On release, classify using the last latched cur (the release-cycle coordinates are ignored):
  - If |dx| >= |dy|: RIGHT if dx >= 0, else LEFT. A tie goes to the horizontal axis.
  - Otherwise: DOWN if dy > 0, else UP.
  - Emit the code with gest_dx/gest_dy set, then go to IDLE.
- WAIT_DTAP:
  - On touch_down=1, latch a new start and go to PRESS2.
  - If the timer reaches DTAP_GAP_CYC-1 with no touch, emit TAP and go to IDLE.
- PRESS2:
  - On release, emit DTAP and go to IDLE.
  - If displacement exceeds SWIPE_DIST, or the timer reaches LONG_PRESS_CYC-1, emit TAP (for the first tap) and demote to PRESS. The start point and timer are kept, so PRESS re-evaluates on the next cycle and produces MOVE or LONG.
- Touch input is never lost; there is no input handshake.

Decomposition:
- Shared package touch_gesture_pkg contains:
  - gesture code constants (GEST_NONE..GEST_UP);
  - the FSM state encoding: IDLE, PRESS, HOLD, MOVE, WAIT_DTAP, PRESS2.
- Sub-module touch_delta_classifier is combinational. From start, cur and SWIPE_DIST it produces:
  - signed dx and dy;
  - an exceed flag;
  - a direction code.
- The FSM, timer and output registers live in touch_gesture_engine.

Test Plan:
- All scenarios use bench parameters LONG_PRESS_CYC=20, DTAP_GAP_CYC=10, SWIPE_DIST=8.
- Tap: down at (100,100) for 5 cycles, then up for 12 cycles -> exactly one gest_valid with code 1 and dx=dy=0, 10 cycles after release; busy drops in the same cycle.
- Double tap: down 5 cycles, up 4 cycles, down 5 cycles, up -> code 2 one cycle after the second release; no TAP is emitted.
- Long press: down stationary at (50,50) for 30 cycles, then release -> code 3 exactly once, after the 20th down cycle; no event at release.
- Swipes:
  - (100,100)->(140,110) -> code 4, dx=+40, dy=+10.
  - (200,200)->(195,150) -> code 7, dx=-5, dy=-50.
  - (300,300)->(280,320) -> tie, so code 5 (LEFT), dx=-20, dy=+20.
- Threshold and jitter: motion of exactly 8 in X -> stays a tap (code 1); motion of 9 -> swipe (code 4).
- Reset and mode:
  - Assert reset during the 3rd down cycle -> no event; busy=0 on the next cycle.
  - With DTAP_EN=0, a 5-cycle tap -> code 1 one cycle after release.
